// File: rtl/uart_rx_cfg_if.sv
// Consumer-side bus of the configurable UART receiver: FIFO pop, error
// clear, show-ahead data and status flags.
interface uart_rx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic                 rd_en;
   logic                 clr_err;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_rdy;
   logic                 fifo_full;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   // Consumer side: pops characters and clears errors
   modport master (
      output rd_en,
      output clr_err,
      input  rx_data,
      input  rx_rdy,
      input  fifo_full,
      input  frame_err,
      input  parity_err,
      input  overrun
   );

   // Receiver side
   modport slave (
      input  rd_en,
      input  clr_err,
      output rx_data,
      output rx_rdy,
      output fifo_full,
      output frame_err,
      output parity_err,
      output overrun
   );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling
// FSM with optional parity and 1/2 stop bits, show-ahead character FIFO and
// sticky framing/parity/overrun flags.
module uart_rx_cfg #(
   parameter int CLK_PER_BAUD = 2604,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          RX,
   uart_rx_cfg_if.slave  bus
);

   localparam int CW = $clog2(CLK_PER_BAUD);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BAUD / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLK_PER_BAUD - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic          ODD_PAR   = (PARITY == 2);
   localparam logic          HAS_PAR   = (PARITY != 0);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic                 rx_m;
   logic                 rx_s;
   logic                 rx_s_d;
   logic [2:0]           state;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_cnt;
   logic                 par_bad;
   logic                 stop_bad;
   logic [DATA_BITS-1:0] shreg;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;

   logic start_det;
   logic strobe;
   logic par_mismatch;
   logic frame_done;
   logic frame_bad;
   logic char_good;
   logic empty;
   logic full;
   logic pop;
   logic push;
   logic drop;
   logic frame_set;
   logic parity_set;
   logic frame_err;
   logic parity_err;
   logic overrun;

   // Two-flop synchroniser plus a delayed copy for falling-edge detection;
   // all preset high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m   <= 1'b1;
         rx_s   <= 1'b1;
         rx_s_d <= 1'b1;
      end else begin
         rx_m   <= RX;
         rx_s   <= rx_m;
         rx_s_d <= rx_s;
      end
   end

   assign start_det = (state == S_IDLE) && rx_s_d && !rx_s;

   // Half a bit into the start bit, then one full bit per sample.
   assign strobe = (state == S_START) ? (cnt == HALF_LAST)
                                      : ((state != S_IDLE) && (cnt == FULL_LAST));

   // Even parity: data xor parity bit must be 0; odd parity: must be 1.
   assign par_mismatch = (^shreg) ^ rx_s ^ ODD_PAR;

   assign frame_done = (state == S_STOP) && strobe && (bit_cnt == STOP_LAST);
   assign frame_bad  = stop_bad || !rx_s;
   assign char_good  = frame_done && !frame_bad && !par_bad;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = bus.rd_en && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push  = char_good && (!full || pop);
   assign drop  = char_good && full && !pop;

   assign frame_set  = frame_done && frame_bad;
   assign parity_set = frame_done && par_bad;

   // Baud counter: restarts on start detect and on every sample strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (start_det || strobe) begin
         cnt <= '0;
      end else if (state != S_IDLE) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Frame sequencer: start qualification, data, optional parity, stop bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         bit_cnt  <= '0;
         par_bad  <= 1'b0;
         stop_bad <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_det) begin
                  state    <= S_START;
                  bit_cnt  <= '0;
                  par_bad  <= 1'b0;
                  stop_bad <= 1'b0;
               end
            end
            S_START: begin
               if (strobe) begin
                  // Line back high at mid-start: a glitch, drop it silently.
                  state   <= rx_s ? S_IDLE : S_DATA;
                  bit_cnt <= '0;
               end
            end
            S_DATA: begin
               if (strobe) begin
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     state   <= HAS_PAR ? S_PAR : S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            S_PAR: begin
               if (strobe) begin
                  par_bad <= par_mismatch;
                  state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (strobe) begin
                  stop_bad <= frame_bad;
                  if (bit_cnt == STOP_LAST) begin
                     state   <= S_IDLE;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Data shift register, LSB arrives first so bits enter at the top.
   always_ff @(posedge clk) begin
      if ((state == S_DATA) && strobe) begin
         shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
   end

   // Character storage; contents need no reset, visibility is gated by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= shreg;
      end
   end

   // FIFO pointers with an extra wrap bit to tell full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Sticky error flags; a new event in the same cycle beats clr_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err  <= frame_set  || (frame_err  && !bus.clr_err);
         parity_err <= parity_set || (parity_err && !bus.clr_err);
         overrun    <= drop       || (overrun    && !bus.clr_err);
      end
   end

   assign bus.rx_data    = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign bus.rx_rdy     = !empty;
   assign bus.fifo_full  = full;
   assign bus.frame_err  = frame_err;
   assign bus.parity_err = parity_err;
   assign bus.overrun    = overrun;

endmodule
